// File: rtl/cnt_ctrl.sv
// cnt_ctrl: start/pause/clear controlled up-counter with a latched terminal
// count, one-shot or periodic (auto-reload) operation and a done pulse.
module cnt_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             start,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_lim;
  logic             r_mode;
  logic             r_done;

  // Control FSM, counter and run-time copies of limit/mode; done is a
  // default-low pulse raised only on the terminal-count edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_lim   <= '0;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clear) begin
        r_state <= S_IDLE;
        r_q     <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_state <= S_RUN;
              r_q     <= '0;
              r_lim   <= limit;
              r_mode  <= mode;
            end
          end
          S_RUN: begin
            if (pause) begin
              r_state <= S_PAUSE;
            end else if (r_q == r_lim) begin
              r_done <= 1'b1;
              if (r_mode) begin
                r_q <= '0;
              end else begin
                r_state <= S_DONE;
              end
            end else begin
              r_q <= r_q + WIDTH'(1);
            end
          end
          S_PAUSE: begin
            if (!pause) begin
              r_state <= S_RUN;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Outputs: registered values straight out, busy decoded from state.
  assign Q     = r_q;
  assign done  = r_done;
  assign state = r_state;
  assign busy  = (r_state == S_RUN) || (r_state == S_PAUSE);

endmodule

// File: tb/tb_cnt_ctrl.sv
// tb_cnt_ctrl: directed scenarios plus randomized stimulus against a
// rule-level reference model of cnt_ctrl.
module tb_cnt_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int          MODV  = 1 << WIDTH;

  logic             CLK = 1'b0;
  logic             RST;
  logic             clear, start, pause, mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] Q;
  logic             busy, done;
  logic [1:0]       state;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state (state numbering matches the output encoding)
  int m_st, m_q, m_done, m_lim, m_mode;

  cnt_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .clear(clear), .start(start), .pause(pause),
    .mode(mode), .limit(limit), .Q(Q), .busy(busy), .done(done),
    .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_q = 0; m_done = 0; m_lim = 0; m_mode = 0;
  endtask

  // one rising edge of the specified behaviour, highest priority first
  task automatic model_edge();
    m_done = 0;
    if (clear) begin
      m_st = 0; m_q = 0;
    end else if ((m_st == 0 || m_st == 3) && start) begin
      m_st = 1; m_q = 0; m_lim = int'(limit); m_mode = int'(mode);
    end else if (m_st == 2) begin
      if (!pause) m_st = 1;
    end else if (m_st == 1) begin
      if (pause) m_st = 2;
      else if (m_q == m_lim) begin
        m_done = 1;
        if (m_mode == 1) m_q = 0; else m_st = 3;
      end else m_q = (m_q + 1) % MODV;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, int'(state), m_st);
    check({tag, ".Q"},     int'(Q),     m_q);
    check({tag, ".done"},  int'(done),  m_done);
    check({tag, ".busy"},  int'(busy),  (m_st == 1 || m_st == 2) ? 1 : 0);
  endtask

  task automatic cyc(input string tag, input logic c, input logic s,
                     input logic p, input logic m, input int l);
    clear = c; start = s; pause = p; mode = m; limit = WIDTH'(l);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // reset pulse entirely inside the low phase of the clock
  task automatic arst(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; clear = 0; start = 0; pause = 0; mode = 0; limit = '0;
    model_reset();
    #2;
    check_all("reset");
    #10;
    @(negedge CLK);
    RST = 1'b0;
    cyc("post_rst", 0, 0, 0, 0, 0);
    check("post_rst_idle", int'(state), 0);

    // one-shot limit 3
    cyc("os3", 0, 1, 0, 0, 3);
    check("os3_q0", int'(Q), 0);
    for (int i = 1; i <= 3; i++) begin
      cyc("os3", 0, 0, 0, 1, 9);
      check("os3_cnt", int'(Q), i);
    end
    cyc("os3_term", 0, 0, 0, 0, 0);
    check("os3_done", int'(done), 1);
    check("os3_state", int'(state), 3);
    cyc("os3_hold", 0, 0, 1, 0, 0);
    check("os3_hold_q", int'(Q), 3);
    check("os3_busy", int'(busy), 0);
    check("os3_done_off", int'(done), 0);

    // periodic limit 2 restarted from DONE
    cyc("per2", 0, 1, 0, 1, 2);
    for (int i = 1; i < 9; i++) begin
      cyc("per2", 0, 1, 0, 0, 7);
      check("per2_q", int'(Q), i % 3);
      check("per2_st", int'(state), 1);
      check("per2_done", int'(done), (i % 3 == 0) ? 1 : 0);
    end

    // periodic limit 5 with a 3-cycle pause at Q=2
    cyc("clr", 1, 0, 0, 0, 0);
    cyc("per5", 0, 1, 0, 1, 5);
    cyc("per5", 0, 0, 0, 0, 0);
    cyc("per5", 0, 0, 0, 0, 0);
    check("per5_at2", int'(Q), 2);
    for (int i = 0; i < 3; i++) cyc("per5_p", 0, 0, 1, 0, 0);
    check("per5_paused", int'(state), 2);
    cyc("per5_res", 0, 0, 0, 0, 0);
    check("per5_res_q", int'(Q), 2);
    for (int i = 3; i <= 5; i++) begin
      cyc("per5_run", 0, 0, 0, 0, 0);
      check("per5_run_q", int'(Q), i);
    end

    // clear + pause + start together in RUN at Q=4
    cyc("clr2", 1, 0, 0, 0, 0);
    cyc("cps", 0, 1, 0, 0, 9);
    for (int i = 0; i < 4; i++) cyc("cps", 0, 0, 0, 0, 0);
    check("cps_at4", int'(Q), 4);
    cyc("cps_clr", 1, 1, 1, 0, 9);
    check("cps_st", int'(state), 0);
    check("cps_q", int'(Q), 0);

    // async reset mid-run at Q=7, limit input changed during the run
    cyc("ar", 0, 1, 0, 0, 12);
    for (int i = 0; i < 7; i++) cyc("ar", 0, 0, 0, 1, 3);
    check("ar_at7", int'(Q), 7);
    arst("ar_async");
    for (int i = 0; i < 3; i++) cyc("ar_idle", 0, 0, 0, 0, 3);
    cyc("ar_new", 0, 1, 0, 0, 3);
    for (int i = 0; i < 4; i++) cyc("ar_new", 0, 0, 0, 0, 12);
    check("ar_new_done", int'(state), 3);

    // limit 0, periodic then one-shot
    cyc("z_per", 0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc("z_per", 0, 0, 0, 0, 5);
      check("z_per_done", int'(done), 1);
    end
    cyc("z_clr", 1, 0, 0, 0, 0);
    cyc("z_os", 0, 1, 0, 0, 0);
    cyc("z_os", 0, 0, 0, 1, 5);
    check("z_os_state", int'(state), 3);
    check("z_os_q", int'(Q), 0);

    // periodic full-range wrap 15 -> 0
    cyc("wrap", 0, 1, 0, 1, MODV - 1);
    for (int i = 0; i < 16; i++) cyc("wrap", 0, 0, 0, 0, 0);
    check("wrap_q", int'(Q), 0);
    check("wrap_done", int'(done), 1);

    // randomized
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) arst("rnd_rst");
      else cyc("rnd",
               logic'($urandom_range(0, 19) == 0),
               logic'($urandom_range(0, 3) == 0),
               logic'($urandom_range(0, 3) == 0),
               logic'($urandom_range(0, 1)),
               int'($urandom_range(0, MODV - 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cnt_ctrl.md
CNT_CTRL -- requirements
Module: cnt_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, counter and limit width in bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; asynchronous, active-high.
REQ-004 clear  input  1  synchronous abort; returns the block to IDLE.
REQ-005 start  input  1  begin a count run; sampled in IDLE or DONE only.
REQ-006 pause  input  1  level; hold the count while high in RUN.
REQ-007 mode  input  1  0 = one-shot, 1 = periodic (auto-reload).
REQ-008 limit  input  WIDTH  terminal count value.
REQ-009 Q  output  WIDTH  current count, registered.
REQ-010 busy  output  1  high in RUN or PAUSE.
REQ-011 done  output  1  registered one-cycle pulse at terminal count.
REQ-012 state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE and DONE, encoded as in REQ-012.
REQ-014 Per-edge priority SHALL be: clear > start (IDLE/DONE only) > pause > terminal count > increment.
REQ-015 clear=1 at an edge SHALL force state=IDLE, Q=0 and done=0, whatever the current state.
REQ-016 In IDLE or DONE with start=1, the block SHALL go to RUN with Q=0, latching limit and mode into internal registers.
REQ-017 limit and mode SHALL be used only from the latched copies during a run; changes while busy have no effect.
REQ-018 start in RUN or PAUSE SHALL be ignored.
REQ-019 In RUN with pause=1, the block SHALL go to PAUSE; Q holds and does not increment on that edge.
REQ-020 In PAUSE with pause=0, the block SHALL return to RUN; Q holds on that edge and increments from the next edge.
REQ-021 In RUN with pause=0 and Q != latched limit, Q SHALL increment by 1 modulo 2^WIDTH.
REQ-022 In RUN with pause=0 and Q == latched limit, in periodic mode, the block SHALL set Q=0, stay in RUN and set done=1 for one cycle.
REQ-023 In RUN with pause=0 and Q == latched limit, in one-shot mode, the block SHALL go to DONE, hold Q at limit and set done=1 for one cycle.
REQ-024 done SHALL be 0 on every edge other than those in REQ-022/023, so it is never high for two consecutive cycles except in the periodic limit=0 case.
REQ-025 With latched limit=0 in periodic mode, Q SHALL stay 0 and done SHALL be high on every RUN cycle.
REQ-026 With latched limit=0 in one-shot mode, the block SHALL enter DONE on the first RUN edge.
REQ-027 A periodic run with limit=2^WIDTH-1 SHALL wrap Q from 15 to 0 (WIDTH=4) with done asserted.
REQ-028 In IDLE, Q SHALL hold its value; in DONE, Q SHALL hold the latched limit.
REQ-029 busy SHALL be combinational from state: 1 in RUN or PAUSE, 0 otherwise.
REQ-030 pause SHALL have no effect in IDLE or DONE.

Reset
REQ-031 RST=1 SHALL immediately, without waiting for CLK, set state=IDLE, Q=0, done=0, busy=0, and clear the latched limit and mode to 0.
REQ-032 Assertion of RST mid-run SHALL abort the run; after release the block waits in IDLE for start.
REQ-033 Deassertion of RST SHALL take effect at the next rising edge of CLK, with no spurious done.

Verification
REQ-034 One-shot, limit=3, start pulsed: Q = 0,1,2,3 on successive cycles, done high for one cycle as state becomes DONE, Q holds 3, busy=0.
REQ-035 Periodic, limit=2, 9 cycles: Q = 0,1,2,0,1,2,0,1,2; done pulses after each 2->0 edge; state stays RUN.
REQ-036 Periodic, limit=5, pause held 3 cycles at Q=2: Q=2 for the pause duration plus 1 resume cycle, then 3,4,5; no count is lost or skipped.
REQ-037 clear and pause asserted together in RUN at Q=4: next state IDLE, Q=0, done=0; start asserted on the same edge is also ignored.
REQ-038 Async RST pulse between clock edges in RUN at Q=7: Q=0 and state=IDLE before the next edge; limit changed during the run is not used until the next start.
REQ-039 Periodic limit=0 and one-shot limit=0: done high every cycle in the periodic case; in the one-shot case, DONE is reached after one edge with Q=0.
